dualmem_port_arbiter: RTL and testbench
=======================================

Name: dualmem_port_arbiter

Overview:
- Shares one port of the 2048 x 64-bit dual-port scratch memory between two requesters, e.g. core data path and DMA engine.
- Round-robin arbitration with a req/gnt handshake.
- Drives the memory port's per-byte en/we, address and write data.
- Returns read data with a registered rvalid routed to the requester that issued the read.
- Sits between the requesters and one port (A or B) of the memory; the other memory port is untouched.

Parameters:
- ADDR_WIDTH, 11, word address width (2048 x 64-bit words)
- DATA_WIDTH, 64, data width; must be a multiple of 8
- BE_WIDTH, DATA_WIDTH/8, byte-lane count; derived, not overridden

Ports:
- clk  in  1  system clock, drives arbiter and memory port
- rst  in  1  synchronous active-high reset
- m0_req  in  1  requester 0 access request
- m0_we  in  BE_WIDTH  requester 0 byte write enables; all zero = read
- m0_addr  in  ADDR_WIDTH  requester 0 word address
- m0_wdata  in  DATA_WIDTH  requester 0 write data
- m0_lock  in  1  requester 0 hold-grant request (used only with the optional feature)
- m0_gnt  out  1  requester 0 access accepted this cycle
- m0_rvalid  out  1  requester 0 read data valid
- m0_rdata  out  DATA_WIDTH  requester 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for requester 1
- mem_en  out  BE_WIDTH  memory port byte enables
- mem_we  out  BE_WIDTH  memory port byte write enables
- mem_addr  out  ADDR_WIDTH  memory port address
- mem_wdata  out  DATA_WIDTH  memory port write data
- mem_rdata  in  DATA_WIDTH  memory port read data, valid one clk after the access

Behaviour:
- Only clk is used; rst is synchronous and active-high.
- Handshake:
  - Requester holds req, we, addr and wdata stable until it sees gnt high.
  - Transfer occurs on the clk edge where req && gnt.
  - gnt is combinational from the req inputs and the arbiter state (zero-wait when uncontended).
- Arbitration:
  - Register last_gnt (1 bit).
  - Both requesting: grant the requester that is not last_gnt.
  - One requesting: grant it.
  - last_gnt updates to the granted index on every transfer and holds otherwise.
  - Reset value of last_gnt is 1, so requester 0 wins the first contention.
- Memory drive, from the granted requester, same cycle:
  - Read: mem_en = all ones, mem_we = 0.
  - Write: mem_en = m*_we, mem_we = m*_we.
  - No grant: mem_en = 0, mem_we = 0. mem_addr and mem_wdata follow requester 0 (don't-care).
- Read return:
  - Registered rd_pending (1 bit) and rd_owner (1 bit) set on a read transfer.
  - m{rd_owner}_rvalid = 1 exactly one cycle after the read transfer; other rvalid = 0.
  - m*_rdata = mem_rdata to both requesters, qualified only by rvalid.
  - Writes produce no rvalid.
- Back-to-back reads: one transfer per cycle, rvalid each following cycle, owners pipelined in order.
- While rst is high:
  - All gnt = 0, mem_en = mem_we = 0.
  - rvalid registers clear; a read accepted in the cycle rst asserts returns no rvalid.
  - last_gnt = 1; lock state returns to IDLE.
- Requester dropping req without gnt: allowed, no side effect.

Optional Feature:
- Macro: DUALMEM_ARB_LOCK_EN.
- Enabled: three-state FSM.
  - IDLE: normal round-robin.
  - A transfer to requester n with mn_lock = 1 moves to LOCKn.
  - LOCKn: only requester n may be granted; the other gnt is forced 0.
  - A transfer to n with mn_lock = 0 returns to IDLE.
  - LOCKn with mn_req low holds LOCKn; the lock persists, no timeout.
  - last_gnt updates as normal.
- Disabled: m*_lock ignored, FSM absent, pure round-robin.

Test Plan:
- Reset then m0 write addr 0x005, we 0xFF, data 0x0123456789ABCDEF; next cycle m0 read 0x005 -> m0_gnt same cycle; m0_rvalid one cycle later with m0_rdata 0x0123456789ABCDEF; m1_rvalid stays 0.
- Both req reads every cycle for 4 cycles after reset -> grants m0, m1, m0, m1; rvalid alternates accordingly, each one cycle after its grant.
- m1 write addr 0x7FF, we 0x0F, data all 0xAA over 0x0 preload -> mem_en = mem_we = 0x0F; read back 0x00000000AAAAAAAA.
- Read granted in the cycle rst rises -> no rvalid the following cycle; first post-reset contention grants m0.
- DUALMEM_ARB_LOCK_EN defined: m1 locked, 3 transfers with m0_req high throughout, lock dropped on the third -> m0_gnt = 0 for all 3; m0 granted the next cycle.
- m0 holds a read at 0x123 while m1 wins contention -> m0 addr held stable, m0 granted next cycle, data correct.

Source files
------------

// File: rtl/dualmem_port_arbiter.sv
// Round-robin arbiter sharing one port of the 2048 x 64-bit scratch memory between two requesters.
// Optional grant-lock FSM is compiled in when DUALMEM_ARB_LOCK_EN is defined.

module dualmem_port_arbiter #(
    parameter  int ADDR_WIDTH = 11,
    parameter  int DATA_WIDTH = 64,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic [BE_WIDTH-1:0]   m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic [BE_WIDTH-1:0]   m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [BE_WIDTH-1:0]   mem_en,
    output logic [BE_WIDTH-1:0]   mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic                last_gnt_q, last_gnt_d;
    logic                rd_pending_q, rd_pending_d;
    logic                rd_owner_q, rd_owner_d;
    logic                allow0, allow1;
    logic                gnt0, gnt1, xfer, xfer_read;
    logic [BE_WIDTH-1:0] sel_we;

`ifdef DUALMEM_ARB_LOCK_EN
    typedef enum logic [1:0] {
        LOCK_IDLE = 2'd0,
        LOCK_0    = 2'd1,
        LOCK_1    = 2'd2
    } lock_state_e;

    lock_state_e lock_q;

    // A lock is held until its owner completes a transfer with lock low.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= LOCK_IDLE;
        end else if (gnt0) begin
            lock_q <= m0_lock ? LOCK_0 : LOCK_IDLE;
        end else if (gnt1) begin
            lock_q <= m1_lock ? LOCK_1 : LOCK_IDLE;
        end
    end

    assign allow0 = (lock_q != LOCK_1);
    assign allow1 = (lock_q != LOCK_0);
`else
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
    assign allow0      = 1'b1;
    assign allow1      = 1'b1;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        sel_we       = m0_we;
        mem_addr     = m0_addr;
        mem_wdata    = m0_wdata;
        mem_en       = '0;
        mem_we       = '0;
        last_gnt_d   = last_gnt_q;
        rd_pending_d = 1'b0;
        rd_owner_d   = rd_owner_q;

        // NOTE: grants are masked by rst so nothing reaches the memory during reset.
        if (!rst) begin
            gnt0 = m0_req && allow0 && (!(m1_req && allow1) ||  last_gnt_q);
            gnt1 = m1_req && allow1 && (!(m0_req && allow0) || !last_gnt_q);
        end

        if (gnt1) begin
            sel_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end

        xfer      = gnt0 || gnt1;
        xfer_read = xfer && (sel_we == '0);

        if (xfer) begin
            mem_en     = xfer_read ? '1 : sel_we;
            mem_we     = sel_we;
            last_gnt_d = gnt1;
        end

        if (xfer_read) begin
            rd_pending_d = 1'b1;
            rd_owner_d   = gnt1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            last_gnt_q   <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rd_pending_q && !rd_owner_q;
    assign m1_rvalid = rd_pending_q &&  rd_owner_q;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dualmem_port_arbiter.sv
// Scoreboard bench for dualmem_port_arbiter with a behavioural memory on the shared port.
// Lock-path expectations follow DUALMEM_ARB_LOCK_EN when the bench is built with it.

module tb_dualmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_lock, m0_gnt, m0_rvalid;
    logic [7:0]  m0_we;
    logic [10:0] m0_addr;
    logic [63:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_lock, m1_gnt, m1_rvalid;
    logic [7:0]  m1_we;
    logic [10:0] m1_addr;
    logic [63:0] m1_wdata, m1_rdata;
    logic [7:0]  mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic        owner;
        logic [63:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t exp_q[$];

    dualmem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory port: byte-lane writes, registered read data; unwritten words read as zero.
    logic [63:0] tb_mem [logic [10:0]];
    logic [63:0] mem_word;

    always @(posedge clk) begin
        if (|mem_en) begin
            mem_word = tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : 64'h0;
            if (mem_we == 8'h00) begin
                mem_rdata <= mem_word;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_we[b]) mem_word[8*b +: 8] = mem_wdata[8*b +: 8];
                end
                tb_mem[mem_addr] = mem_word;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every queued read must return on exactly its due cycle, to its owner, with its data.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check("rvalid_cycle", 64'(cyc), 64'(e.due));
            check("rvalid_route", {62'b0, m1_rvalid, m0_rvalid}, e.owner ? 64'd2 : 64'd1);
            check("rdata", e.owner ? m1_rdata : m0_rdata, e.data);
        end else if (m0_rvalid || m1_rvalid) begin
            check("rvalid_spurious", {62'b0, m1_rvalid, m0_rvalid}, 64'd0);
        end
    end

    task automatic set_m0(input logic req, input logic [7:0] we, input logic [10:0] addr,
                          input logic [63:0] wd, input logic lock);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_lock = lock;
    endtask

    task automatic set_m1(input logic req, input logic [7:0] we, input logic [10:0] addr,
                          input logic [63:0] wd, input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_lock = lock;
    endtask

    task automatic expect_rd(input logic owner, input logic [63:0] data);
        exp_q.push_back('{owner: owner, data: data, due: 32'(cyc + 1)});
    endtask

    // One clock: check the combinational grant and memory drive mid-cycle, then advance.
    task automatic step(input string tag, input logic g0, input logic g1, input logic [7:0] en,
                        input logic [7:0] we, input logic [10:0] addr, input logic [63:0] wd);
        @(negedge clk);
        check({tag, "_gnt0"}, {63'b0, m0_gnt}, {63'b0, g0});
        check({tag, "_gnt1"}, {63'b0, m1_gnt}, {63'b0, g1});
        check({tag, "_en"}, {56'b0, mem_en}, {56'b0, en});
        check({tag, "_we"}, {56'b0, mem_we}, {56'b0, we});
        if (en != 8'h00) check({tag, "_addr"}, {53'b0, mem_addr}, {53'b0, addr});
        if (we != 8'h00) check({tag, "_wdata"}, mem_wdata, wd);
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] D010 = 64'h1000_0000_0000_0010;
    localparam logic [63:0] D011 = 64'h1000_0000_0000_0011;
    localparam logic [63:0] D020 = 64'h2000_0000_0000_0020;
    localparam logic [63:0] D021 = 64'h2000_0000_0000_0021;
    localparam logic [63:0] D123 = 64'h0000_0123_CAFE_0123;
    localparam logic [63:0] D300 = 64'h0000_0300_BEEF_0300;

    initial begin
        rst = 1'b1;
        set_m0(1'b1, 8'h00, 11'h000, 64'h0, 1'b0);
        set_m1(1'b1, 8'h00, 11'h000, 64'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state: requests present but nothing granted or returned.
        step("rst_hold", 1'b0, 1'b0, 8'h00, 8'h00, 11'h000, 64'h0);
        check("rst_rvalid", {62'b0, m1_rvalid, m0_rvalid}, 64'd0);
        rst = 1'b0;
        set_m1(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);

        // Preload through the arbiter with requester 0 alone.
        set_m0(1'b1, 8'hFF, 11'h010, D010, 1'b0); step("pre010", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h010, D010);
        set_m0(1'b1, 8'hFF, 11'h011, D011, 1'b0); step("pre011", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h011, D011);
        set_m0(1'b1, 8'hFF, 11'h020, D020, 1'b0); step("pre020", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h020, D020);
        set_m0(1'b1, 8'hFF, 11'h021, D021, 1'b0); step("pre021", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h021, D021);
        set_m0(1'b1, 8'hFF, 11'h123, D123, 1'b0); step("pre123", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h123, D123);
        set_m0(1'b1, 8'hFF, 11'h300, D300, 1'b0); step("pre300", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h300, D300);
        set_m0(1'b1, 8'hFF, 11'h7FF, 64'h0, 1'b0); step("pre7ff", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h7FF, 64'h0);

        // Fresh reset (last_gnt was left at 0), then four contended reads: m0, m1, m0, m1.
        set_m0(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);
        rst = 1'b1;
        step("rst2", 1'b0, 1'b0, 8'h00, 8'h00, 11'h000, 64'h0);
        rst = 1'b0;
        set_m0(1'b1, 8'h00, 11'h010, 64'h0, 1'b0);
        set_m1(1'b1, 8'h00, 11'h020, 64'h0, 1'b0);
        expect_rd(1'b0, D010); step("rr1", 1'b1, 1'b0, 8'hFF, 8'h00, 11'h010, 64'h0);
        m0_addr = 11'h011;
        expect_rd(1'b1, D020); step("rr2", 1'b0, 1'b1, 8'hFF, 8'h00, 11'h020, 64'h0);
        m1_addr = 11'h021;
        expect_rd(1'b0, D011); step("rr3", 1'b1, 1'b0, 8'hFF, 8'h00, 11'h011, 64'h0);
        expect_rd(1'b1, D021); step("rr4", 1'b0, 1'b1, 8'hFF, 8'h00, 11'h021, 64'h0);
        set_m0(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);
        set_m1(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);

        // Requester 0 full write then read back.
        set_m0(1'b1, 8'hFF, 11'h005, 64'h0123456789ABCDEF, 1'b0);
        step("m0_wr", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h005, 64'h0123456789ABCDEF);
        set_m0(1'b1, 8'h00, 11'h005, 64'h0, 1'b0);
        expect_rd(1'b0, 64'h0123456789ABCDEF);
        step("m0_rd", 1'b1, 1'b0, 8'hFF, 8'h00, 11'h005, 64'h0);
        set_m0(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);

        // Requester 1 partial write over a zero word, then read back.
        set_m1(1'b1, 8'h0F, 11'h7FF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
        step("m1_pwr", 1'b0, 1'b1, 8'h0F, 8'h0F, 11'h7FF, 64'hAAAA_AAAA_AAAA_AAAA);
        set_m1(1'b1, 8'h00, 11'h7FF, 64'h0, 1'b0);
        expect_rd(1'b1, 64'h0000_0000_AAAA_AAAA);
        step("m1_rd", 1'b0, 1'b1, 8'hFF, 8'h00, 11'h7FF, 64'h0);
        set_m1(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);

        // m0 transfers alone, so m1 wins the next contention while m0 holds its read.
        set_m0(1'b1, 8'hFF, 11'h200, 64'h5555_0000_0000_0200, 1'b0);
        step("m0_solo", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h200, 64'h5555_0000_0000_0200);
        set_m0(1'b1, 8'h00, 11'h123, 64'h0, 1'b0);
        set_m1(1'b1, 8'h00, 11'h300, 64'h0, 1'b0);
        expect_rd(1'b1, D300); step("hold_m1", 1'b0, 1'b1, 8'hFF, 8'h00, 11'h300, 64'h0);
        set_m1(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);
        expect_rd(1'b0, D123); step("hold_m0", 1'b1, 1'b0, 8'hFF, 8'h00, 11'h123, 64'h0);
        set_m0(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);
        step("idle", 1'b0, 1'b0, 8'h00, 8'h00, 11'h000, 64'h0);

        // Reads pending when rst rises are dropped; first contention afterwards goes to m0.
        set_m0(1'b1, 8'h00, 11'h123, 64'h0, 1'b0);
        set_m1(1'b1, 8'h00, 11'h300, 64'h0, 1'b0);
        rst = 1'b1;
        step("rst_rd", 1'b0, 1'b0, 8'h00, 8'h00, 11'h000, 64'h0);
        rst = 1'b0;
        expect_rd(1'b0, D123); step("post_rst0", 1'b1, 1'b0, 8'hFF, 8'h00, 11'h123, 64'h0);
        set_m0(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);
        expect_rd(1'b1, D300); step("post_rst1", 1'b0, 1'b1, 8'hFF, 8'h00, 11'h300, 64'h0);
        set_m1(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);

        // Lock sequence: m0 transfers so that m1 wins the contention and takes the lock.
        set_m0(1'b1, 8'hFF, 11'h201, 64'h0000_0000_0000_0201, 1'b0);
        step("lk_pre", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h201, 64'h0000_0000_0000_0201);
        set_m0(1'b1, 8'hFF, 11'h203, 64'h0000_0000_0000_0203, 1'b0);
        set_m1(1'b1, 8'hFF, 11'h202, 64'h0000_0000_0000_0202, 1'b1);
        step("lk_c1", 1'b0, 1'b1, 8'hFF, 8'hFF, 11'h202, 64'h0000_0000_0000_0202);
        set_m1(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);
`ifdef DUALMEM_ARB_LOCK_EN
        step("lk_gap", 1'b0, 1'b0, 8'h00, 8'h00, 11'h000, 64'h0);
        set_m1(1'b1, 8'hFF, 11'h204, 64'h0000_0000_0000_0204, 1'b1);
        step("lk_c2", 1'b0, 1'b1, 8'hFF, 8'hFF, 11'h204, 64'h0000_0000_0000_0204);
        set_m1(1'b1, 8'hFF, 11'h205, 64'h0000_0000_0000_0205, 1'b0);
        step("lk_c3", 1'b0, 1'b1, 8'hFF, 8'hFF, 11'h205, 64'h0000_0000_0000_0205);
        set_m1(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);
        step("lk_rel", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h203, 64'h0000_0000_0000_0203);
`else
        step("nolk_m0", 1'b1, 1'b0, 8'hFF, 8'hFF, 11'h203, 64'h0000_0000_0000_0203);
        set_m0(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);
        set_m1(1'b1, 8'hFF, 11'h204, 64'h0000_0000_0000_0204, 1'b1);
        step("nolk_m1", 1'b0, 1'b1, 8'hFF, 8'hFF, 11'h204, 64'h0000_0000_0000_0204);
`endif
        set_m0(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);
        set_m1(1'b0, 8'h00, 11'h000, 64'h0, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
